// File: rtl/btn_pkg.sv
// Shared types and constants for the button event controller.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } btn_state_e;

  // Cycle counts at a 50 MHz sys_clk.
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_LONG_CYC     = 50_000_000;
  localparam int DEF_DCLICK_CYC   = 15_000_000;
  localparam int DEF_REPEAT_CYC   = 10_000_000;

  // Counter width for a count that reaches n-1, at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The gesture timer must reach the largest of the three timeouts.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return cnt_width(m);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, debounce counter and press/release edge flags for one key.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic press_f,
  output logic rel_f
);

  localparam int DW = cnt_width(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          btn_m;
  logic          btn_s;
  logic [DW-1:0] db_cnt;
  logic [1:0]    lvl_r;

  // Two-flop synchroniser; i_btn has no relation to sys_clk.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= i_btn;
      btn_s <= btn_m;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYC cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_cnt  <= '0;
      o_level <= 1'b0;
    end else if (btn_s == o_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt  <= '0;
      o_level <= btn_s;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // History of the debounced level for edge extraction.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) lvl_r <= 2'b00;
    else            lvl_r <= {lvl_r[0], o_level};
  end

  assign press_f = lvl_r[0] & ~lvl_r[1];
  assign rel_f   = lvl_r[1] & ~lvl_r[0];

endmodule

// File: rtl/btn_event_ctrl.sv
// Button gesture classifier: short press, long press, double click.
// Optional auto-repeat while held long is enabled by defining BTN_REPEAT_EN.
module btn_event_ctrl
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int DCLICK_CYC   = DEF_DCLICK_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic o_repeat,
  output logic o_busy
);

  localparam int TW = tmr_width(LONG_CYC, DCLICK_CYC, REPEAT_CYC);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] DCLK_LAST = TW'(DCLICK_CYC - 1);
  localparam logic [TW-1:0] TMR_MAX   = '1;

  btn_state_e    state, state_nxt;
  logic [TW-1:0] tmr;
  logic          press_f, rel_f;
  logic          tmr_clr;
  logic          short_d, long_d, dbl_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_btn     (i_btn),
    .o_level   (o_level),
    .press_f   (press_f),
    .rel_f     (rel_f)
  );

`ifdef BTN_REPEAT_EN
  localparam logic [TW-1:0] REP_LAST = TW'(REPEAT_CYC - 1);
  logic rep_d;
`endif

  // Next-state and event decode; edges take priority over timeouts.
  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    dbl_d     = 1'b0;
`ifdef BTN_REPEAT_EN
    rep_d     = 1'b0;
`endif
    case (state)
      IDLE:   if (press_f) state_nxt = PRESS1;
      PRESS1: begin
        if (rel_f) state_nxt = WAIT2;
        else if (tmr == LONG_LAST) begin
          long_d    = 1'b1;
          state_nxt = HOLD;
        end
      end
      WAIT2: begin
        if (press_f) state_nxt = PRESS2;
        else if (tmr == DCLK_LAST) begin
          short_d   = 1'b1;
          state_nxt = IDLE;
        end
      end
      PRESS2: begin
        if (rel_f) begin
          dbl_d     = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (rel_f) state_nxt = IDLE;
`ifdef BTN_REPEAT_EN
        else if (tmr == REP_LAST) begin
          rep_d   = 1'b1;
          tmr_clr = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Gesture timer: restarts on any state change, saturates instead of wrapping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                          tmr <= '0;
    else if (state_nxt != state || tmr_clr)  tmr <= '0;
    else if (state != IDLE && tmr != TMR_MAX) tmr <= tmr + 1'b1;
  end

  // Registered one-cycle event pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
    end else begin
      short_press  <= short_d;
      long_press   <= long_d;
      double_click <= dbl_d;
    end
  end

`ifdef BTN_REPEAT_EN
  // Registered auto-repeat pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) o_repeat <= 1'b0;
    else            o_repeat <= rep_d;
  end
`else
  assign o_repeat = 1'b0;
`endif

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with small cycle counts.
module tb_btn_event_ctrl;

  localparam int D  = 4;
  localparam int L  = 20;
  localparam int DC = 10;
  localparam int R  = 5;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic i_btn = 1'b0;
  logic o_level, short_press, long_press, double_click, o_repeat, o_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // event monitor state
  int n_short, n_long, n_dbl, n_rep, n_rise, n_multi;
  int t_short, t_long, t_dbl, t_rep, t_rise;
  bit busy_seen;
  logic prev_lvl = 1'b0;

  btn_event_ctrl #(
    .DEBOUNCE_CYC(D), .LONG_CYC(L), .DCLICK_CYC(DC), .REPEAT_CYC(R)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .i_btn        (i_btn),
    .o_level      (o_level),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .o_repeat     (o_repeat),
    .o_busy       (o_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Count pulses and remember the edge number of the latest one.
  always @(negedge sys_clk) begin
    if (short_press)  begin n_short++; t_short = cyc; end
    if (long_press)   begin n_long++;  t_long  = cyc; end
    if (double_click) begin n_dbl++;   t_dbl   = cyc; end
    if (o_repeat)     begin n_rep++;   t_rep   = cyc; end
    if (o_level && !prev_lvl) begin n_rise++; t_rise = cyc; end
    if ((32'(short_press) + 32'(long_press) + 32'(double_click)) > 1) n_multi++;
    if (o_busy) busy_seen = 1'b1;
    prev_lvl = o_level;
  end

  task automatic clr();
    n_short = 0; n_long = 0; n_dbl = 0; n_rep = 0; n_rise = 0; n_multi = 0;
    t_short = -1; t_long = -1; t_dbl = -1; t_rep = -1; t_rise = -1;
    busy_seen = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    wait_cyc(3);
    checks++;
    if ({o_level, short_press, long_press, double_click, o_repeat, o_busy} !== 6'b0) begin
      errors++; $display("FAIL reset_hold outputs=%b exp=000000",
        {o_level, short_press, long_press, double_click, o_repeat, o_busy});
    end
    sys_rst_n = 1'b1;
    wait_cyc(1);
    checks++;
    if ({o_level, short_press, long_press, double_click, o_repeat, o_busy} !== 6'b0) begin
      errors++; $display("FAIL reset_first_edge outputs=%b exp=000000",
        {o_level, short_press, long_press, double_click, o_repeat, o_busy});
    end
    wait_cyc(2);
  endtask

  task automatic test_glitch();
    clr();
    i_btn = 1'b1; wait_cyc(3); i_btn = 1'b0; wait_cyc(20);
    checks++;
    if (n_rise !== 0) begin errors++; $display("FAIL glitch_level rises=%0d exp=0", n_rise); end
    checks++;
    if (busy_seen !== 1'b0) begin errors++; $display("FAIL glitch_busy seen=%0b exp=0", busy_seen); end
    checks++;
    if (n_short + n_long + n_dbl + n_rep !== 0) begin
      errors++; $display("FAIL glitch_events got=%0d exp=0", n_short + n_long + n_dbl + n_rep);
    end
  endtask

  task automatic test_short();
    int r;
    clr();
    i_btn = 1'b1; wait_cyc(14);
    r = cyc; i_btn = 1'b0; wait_cyc(30);
    checks++;
    if (n_short !== 1) begin errors++; $display("FAIL short_count got=%0d exp=1", n_short); end
    checks++;
    if (t_short !== r + 18) begin errors++; $display("FAIL short_time got=%0d exp=%0d", t_short, r + 18); end
    checks++;
    if (n_long + n_dbl + n_rep !== 0) begin
      errors++; $display("FAIL short_others got=%0d exp=0", n_long + n_dbl + n_rep);
    end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL short_busy got=%0b exp=0", o_busy); end
  endtask

  // gap = cycles from first release input to second press input
  task automatic test_double(input int gap, input string nm);
    int r2;
    clr();
    i_btn = 1'b1; wait_cyc(14);
    i_btn = 1'b0; wait_cyc(gap);
    i_btn = 1'b1; wait_cyc(12);
    r2 = cyc; i_btn = 1'b0; wait_cyc(30);
    checks++;
    if (n_dbl !== 1 || t_dbl !== r2 + 8) begin
      errors++; $display("FAIL %s_dbl count=%0d at=%0d exp=1 at %0d", nm, n_dbl, t_dbl, r2 + 8);
    end
    checks++;
    if (n_short + n_long + n_rep !== 0) begin
      errors++; $display("FAIL %s_others got=%0d exp=0", nm, n_short + n_long + n_rep);
    end
  endtask

  task automatic test_rel_beats_long();
    int r;
    clr();
    i_btn = 1'b1; wait_cyc(20);
    r = cyc; i_btn = 1'b0; wait_cyc(30);
    checks++;
    if (n_long !== 0) begin errors++; $display("FAIL relvslong_long got=%0d exp=0", n_long); end
    checks++;
    if (n_short !== 1 || t_short !== r + 18) begin
      errors++; $display("FAIL relvslong_short count=%0d at=%0d exp=1 at %0d", n_short, t_short, r + 18);
    end
  endtask

  task automatic test_long();
    int c;
    clr();
    c = cyc; i_btn = 1'b1; wait_cyc(40);
    i_btn = 1'b0; wait_cyc(30);
    checks++;
    if (n_long !== 1 || t_long !== c + 28) begin
      errors++; $display("FAIL long_pulse count=%0d at=%0d exp=1 at %0d", n_long, t_long, c + 28);
    end
    checks++;
    if (n_short + n_dbl + n_multi !== 0) begin
      errors++; $display("FAIL long_release_events got=%0d exp=0", n_short + n_dbl + n_multi);
    end
`ifdef BTN_REPEAT_EN
    checks++;
    if (n_rep !== 3 || t_rep !== c + 43) begin
      errors++; $display("FAIL long_repeat count=%0d last=%0d exp=3 last %0d", n_rep, t_rep, c + 43);
    end
`else
    checks++;
    if (n_rep !== 0) begin errors++; $display("FAIL long_repeat count=%0d exp=0", n_rep); end
`endif
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL long_busy got=%0b exp=0", o_busy); end
  endtask

  task automatic test_bounce();
    int s;
    clr();
    for (int k = 0; k < 3; k++) begin
      i_btn = 1'b1; wait_cyc(2);
      i_btn = 1'b0; wait_cyc(2);
    end
    s = cyc; i_btn = 1'b1; wait_cyc(12);
    checks++;
    if (n_rise !== 1 || t_rise !== s + 6) begin
      errors++; $display("FAIL bounce_level rises=%0d at=%0d exp=1 at %0d", n_rise, t_rise, s + 6);
    end
    i_btn = 1'b0; wait_cyc(30);
    checks++;
    if (n_short !== 1 || n_long + n_dbl !== 0) begin
      errors++; $display("FAIL bounce_events short=%0d other=%0d exp=1/0", n_short, n_long + n_dbl);
    end
  endtask

  task automatic test_reset_wait2();
    clr();
    i_btn = 1'b1; wait_cyc(14);
    i_btn = 1'b0; wait_cyc(12);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL rstw2_busy_before got=%0b exp=1", o_busy); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_level, short_press, long_press, double_click, o_repeat, o_busy} !== 6'b0) begin
      errors++; $display("FAIL rstw2_async outputs=%b exp=000000",
        {o_level, short_press, long_press, double_click, o_repeat, o_busy});
    end
    @(negedge sys_clk); sys_rst_n = 1'b1;
    clr();
    wait_cyc(30);
    checks++;
    if (n_short !== 0) begin errors++; $display("FAIL rstw2_short got=%0d exp=0", n_short); end
    checks++;
    if (busy_seen !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rstw2_busy seen=%0b now=%0b exp=0", busy_seen, o_busy);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_glitch();
    test_short();
    test_double(6, "dbl");
    test_double(10, "dbl_edge");
    test_rel_beats_long();
    test_long();
    test_bounce();
    test_reset_wait2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
